cp0_ctrl: RTL

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS-style coprocessor 0 register block.
// Holds Status, Cause, EPC, BadVAddr, Count and Compare. It also handles
// exception/eret commit, mtc0 writes and the interrupt request.
// Count advances once every COUNT_DIV clocks. Commit events are frozen while
// writeback is stalled, but the timer and interrupt sampling keep running.
module cp0_ctrl #(
  parameter int          N_HW_INT   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  output logic [31:0]         rdata,
  input  logic                stall,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                exc_bd,
  input  logic [31:0]         exc_pc,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  output logic                int_req,
  output logic [31:0]         exc_target,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         count_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Architectural state
  logic [PW-1:0] presc_q,    presc_d;
  logic [31:0]   count_q,    count_d;
  logic [31:0]   compare_q,  compare_d;
  logic [7:0]    im_q,       im_d;
  logic          exl_q,      exl_d;
  logic          ie_q,       ie_d;
  logic          bd_q,       bd_d;
  logic          ti_q,       ti_d;
  logic [1:0]    ip_sw_q,    ip_sw_d;
  logic [5:0]    ip_hw_q,    ip_hw_d;
  logic [4:0]    exccode_q,  exccode_d;
  logic [31:0]   epc_q,      epc_d;
  logic [31:0]   badvaddr_q, badvaddr_d;

  // Hardware interrupt lines zero-extended to the six architectural slots
  logic [5:0] ext_pad;

  generate
    if (N_HW_INT >= 6) begin : g_full
      assign ext_pad = ext_int[5:0];
    end else begin : g_pad
      assign ext_pad = {{(6 - N_HW_INT){1'b0}}, ext_int};
    end
  endgenerate

  // Assembled views of Status and Cause. IP7 is shared by the timer and line 5.
  logic [7:0]  ip_all;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  assign ip_all     = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip_all, 1'b0, exccode_q, 2'b0};

  assign status_o = status_val;
  assign cause_o  = cause_val;
  assign epc_o    = epc_q;
  assign count_o  = count_q;

  assign int_req    = ie_q & ~exl_q & (|(ip_all & im_q));
  assign exc_target = eret ? epc_q : EXC_VECTOR;

  // Read port: returns current register contents (writes land at the next edge)
  always_comb begin
    rdata = 32'h0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status_val;
      REG_CAUSE:    rdata = cause_val;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID_VALUE;
      default:      rdata = 32'h0;
    endcase
  end

  // Next-state logic: timer, interrupt sampling, then one commit event by priority
  always_comb begin
    logic cmp_wr;

    presc_d    = presc_q;
    count_d    = count_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = ext_pad;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    cmp_wr     = 1'b0;

    // Free-running prescaler and Count; these keep going through a stall
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (!stall) begin
      if (exc_valid) begin
        // A nested exception must not clobber the original return address
        if (!exl_q) begin
          epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
          bd_d  = exc_bd;
        end
        exl_d     = 1'b1;
        exccode_d = exc_code;
        if ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES)) begin
          badvaddr_d = exc_badvaddr;
        end
      end else if (eret) begin
        exl_d = 1'b0;
      end else if (we) begin
        case (waddr)
          REG_COUNT: begin
            // A software load replaces this cycle's tick and restarts the prescaler
            count_d = wdata;
            presc_d = '0;
          end
          REG_COMPARE: begin
            compare_d = wdata;
            cmp_wr    = 1'b1;
          end
          REG_STATUS: begin
            im_d  = wdata[15:8];
            exl_d = wdata[1];
            ie_d  = wdata[0];
          end
          REG_CAUSE: begin
            ip_sw_d = wdata[9:8];
          end
          REG_EPC: begin
            epc_d = wdata;
          end
          default: begin
          end
        endcase
      end
    end

    // A Compare write acknowledges the timer interrupt and takes precedence over a new match
    if (cmp_wr) begin
      ti_d = 1'b0;
    end else if ((compare_q != 32'h0) && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      im_q       <= 8'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'b0;
      ip_hw_q    <= 6'b0;
      exccode_q  <= 5'b0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

endmodule
